// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the data cache (word, address split, frame, FSM states)
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef struct packed {
    logic [25:0] tag;
    logic [2:0]  idx;
    logic        blkoff;
    logic [1:0]  bytoff;
  } dcachef_t;
  typedef enum logic [3:0] {IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE} dcache_state_t;
  typedef struct packed {
    logic        valid;
    logic        dirty;
    logic [25:0] tag;
    word_t [1:0] data;
  } frame_t;
endpackage

// File: rtl/dcache_frame.sv
// dcache_frame: one cache frame (valid, dirty, tag, 2 words) with a single write port
//   CLK, nRST : clock, async active-low reset (clears the frame)
//   we, wdata : whole-frame write enable and data
//   frame     : current frame contents
module dcache_frame import cpu_types_pkg::*; (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   we,
  input  frame_t wdata,
  output frame_t frame
);
  frame_t frame_q;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) frame_q <= '0;
    else if (we) frame_q <= wdata;
  assign frame = frame_q;
endmodule

// File: rtl/dcache.sv
// dcache: 2-way set-associative write-back data cache with LRU replacement and halt flush
//   CLK, nRST                 : clock, async active-low reset
//   dmemREN/WEN/addr/store    : datapath request; dhit/dmemload answer it
//   halt, flushed             : flush request, sticky flush-complete flag
//   dREN/dWEN/daddr/dstore    : memory request; dwait/dload memory response
module dcache import cpu_types_pkg::*; #(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);
  localparam int FRAMES = SETS * WAYS;
  dcachef_t req;
  frame_t frm [FRAMES];
  frame_t wdata, f0, f1, hf, vic, fl;
  logic wen, m0, m1, hit, hway, vway, last, unused_bytoff;
  logic [3:0] wsel;
  dcache_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  word_t buf_q, buf_d;
  logic [SETS-1:0] lru_q, lru_d;
  // frame number = {set, way}, so the flush counter walks set 0..7, way 0 then 1
  for (genvar f = 0; f < FRAMES; f++) begin : g_frame
    dcache_frame u_frame (.CLK(CLK), .nRST(nRST), .we(wen && wsel == 4'(f)), .wdata(wdata), .frame(frm[f]));
  end
  assign req = dcachef_t'(dmemaddr);
  assign unused_bytoff = ^req.bytoff;
  assign f0 = frm[{req.idx, 1'b0}];
  assign f1 = frm[{req.idx, 1'b1}];
  assign m0 = f0.valid && f0.tag == req.tag;
  assign m1 = f1.valid && f1.tag == req.tag;
  assign hway = m1;
  assign hf = hway ? f1 : f0;
  assign vway = lru_q[req.idx];
  assign vic = vway ? f1 : f0;
  assign fl = frm[cnt_q];
  assign last = cnt_q == 4'(FRAMES - 1);
  assign hit = state_q == IDLE && (dmemREN || dmemWEN) && (m0 || m1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    lru_d = lru_q;
    wen = 1'b0;
    wsel = {req.idx, hway};
    wdata = hf;
    dhit = hit;
    dmemload = hit ? hf.data[req.blkoff] : '0;
    dREN = 1'b0;
    dWEN = 1'b0;
    daddr = '0;
    dstore = '0;
    flushed = 1'b0;
    case (state_q)
      IDLE:
        if (hit) begin
          lru_d[req.idx] = ~hway;
          if (dmemWEN) begin
            wen = 1'b1;
            wdata.dirty = 1'b1;
            wdata.data[req.blkoff] = dmemstore;
          end
        end else if (dmemREN || dmemWEN) state_d = (vic.valid && vic.dirty) ? WB0 : LD0;
        else if (halt) state_d = FLUSH;
      WB0, WB1: begin
        dWEN = 1'b1;
        daddr = {vic.tag, req.idx, state_q == WB1, 2'b00};
        dstore = vic.data[state_q == WB1];
        if (!dwait) state_d = state_q == WB0 ? WB1 : LD0;
      end
      LD0, LD1: begin
        dREN = 1'b1;
        daddr = {req.tag, req.idx, state_q == LD1, 2'b00};
        // word 0 is buffered so a reset mid-fill never leaves a half-written valid frame
        if (!dwait && state_q == LD0) begin
          buf_d = dload;
          state_d = LD1;
        end else if (!dwait) begin
          wen = 1'b1;
          wsel = {req.idx, vway};
          wdata = frame_t'{valid: 1'b1, dirty: 1'b0, tag: req.tag, data: {dload, buf_q}};
          lru_d[req.idx] = ~vway;
          state_d = IDLE;
        end
      end
      FLUSH:
        if (fl.valid && fl.dirty) state_d = FWB0;
        else begin
          state_d = last ? DONE : FLUSH;
          cnt_d = last ? cnt_q : cnt_q + 4'd1;
        end
      FWB0, FWB1: begin
        dWEN = 1'b1;
        daddr = {fl.tag, cnt_q[3:1], state_q == FWB1, 2'b00};
        dstore = fl.data[state_q == FWB1];
        if (!dwait && state_q == FWB0) state_d = FWB1;
        else if (!dwait) begin
          wen = 1'b1;
          wsel = cnt_q;
          wdata = fl;
          wdata.dirty = 1'b0;
          state_d = last ? DONE : FLUSH;
          cnt_d = last ? cnt_q : cnt_q + 4'd1;
        end
      end
      DONE: flushed = 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      buf_q <= '0;
      lru_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
      lru_q <= lru_d;
    end
endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed self-checking bench for dcache
module tb_dcache;
  logic CLK = 1'b0;
  logic nRST, dmemREN, dmemWEN, halt, dwait;
  logic [31:0] dmemaddr, dmemstore, dload;
  logic dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;
  int n_assert = 0;
  int n_fail = 0;
  dcache #(.SETS(8), .WAYS(2)) dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .halt(halt), .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #3;
  endtask
  task automatic rq(input logic r, input logic w, input logic [31:0] a, input logic [31:0] s);
    dmemREN = r;
    dmemWEN = w;
    dmemaddr = a;
    dmemstore = s;
  endtask
  task automatic miss_fill(input string tag, input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1);
    #1;
    chk({tag, " miss dhit"}, dhit, 0);
    tick;
    dload = w0;
    #1;
    chk({tag, " ld0 dREN"}, dREN, 1);
    chk({tag, " ld0 daddr"}, daddr, {a[31:3], 3'b000});
    chk({tag, " ld0 dhit"}, dhit, 0);
    tick;
    dload = w1;
    #1;
    chk({tag, " ld1 daddr"}, daddr, {a[31:3], 3'b100});
    chk({tag, " ld1 dWEN"}, dWEN, 0);
    tick;
  endtask
  logic [31:0] wa [4];
  logic [31:0] wd [4];
  int nw, both, cyc;
  initial begin
    nRST = 1'b1;
    rq(0, 0, 0, 0);
    halt = 0;
    dwait = 0;
    dload = 0;
    #1 nRST = 1'b0;
    #1;
    chk("rst dhit", dhit, 0);
    chk("rst flushed", flushed, 0);
    chk("rst dREN", dREN, 0);
    chk("rst dWEN", dWEN, 0);
    chk("rst daddr", daddr, 0);
    chk("rst dstore", dstore, 0);
    chk("rst dmemload", dmemload, 0);
    tick;
    tick;
    nRST = 1'b1;
    // cold load miss then hits on both words
    rq(1, 0, 32'h40, 0);
    miss_fill("ld40", 32'h40, 32'hDEAD_BEEF, 32'h1111_2222);
    #1;
    chk("ld40 dhit", dhit, 1);
    chk("ld40 data", dmemload, 32'hDEAD_BEEF);
    tick;
    rq(1, 0, 32'h44, 0);
    #1;
    chk("ld44 dhit", dhit, 1);
    chk("ld44 data", dmemload, 32'h1111_2222);
    tick;
    // store hit, then readback
    rq(0, 1, 32'h40, 32'h0000_CAFE);
    #1;
    chk("st40 dhit", dhit, 1);
    tick;
    rq(1, 0, 32'h40, 0);
    #1;
    chk("rd40 data", dmemload, 32'h0000_CAFE);
    tick;
    // fill way 1 of set 0, then evict dirty way 0
    rq(1, 0, 32'h240, 0);
    miss_fill("ld240", 32'h240, 32'h0000_00A0, 32'h0000_00A4);
    #1;
    chk("ld240 data", dmemload, 32'h0000_00A0);
    tick;
    rq(1, 0, 32'h440, 0);
    #1;
    chk("ld440 miss dhit", dhit, 0);
    tick;
    #1;
    chk("wb0 dWEN", dWEN, 1);
    chk("wb0 dREN", dREN, 0);
    chk("wb0 daddr", daddr, 32'h40);
    chk("wb0 dstore", dstore, 32'h0000_CAFE);
    chk("wb0 dhit", dhit, 0);
    tick;
    #1;
    chk("wb1 daddr", daddr, 32'h44);
    chk("wb1 dstore", dstore, 32'h1111_2222);
    tick;
    dload = 32'h0000_00B0;
    #1;
    chk("ld440 ld0 dREN", dREN, 1);
    chk("ld440 ld0 dWEN", dWEN, 0);
    chk("ld440 ld0 daddr", daddr, 32'h440);
    tick;
    dload = 32'h0000_00B4;
    #1;
    chk("ld440 ld1 daddr", daddr, 32'h444);
    tick;
    #1;
    chk("ld440 dhit", dhit, 1);
    chk("ld440 data", dmemload, 32'h0000_00B0);
    tick;
    // memory stalls in LD0
    rq(1, 0, 32'h48, 0);
    dwait = 1;
    #1;
    chk("ld48 miss dhit", dhit, 0);
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall dREN", dREN, 1);
      chk("stall daddr", daddr, 32'h48);
      chk("stall dhit", dhit, 0);
      tick;
    end
    dwait = 0;
    dload = 32'h0000_00C0;
    #1;
    chk("stall end daddr", daddr, 32'h48);
    tick;
    dload = 32'h0000_00C4;
    #1;
    chk("ld48 ld1 daddr", daddr, 32'h4C);
    tick;
    #1;
    chk("ld48 dhit", dhit, 1);
    chk("ld48 data", dmemload, 32'h0000_00C0);
    tick;
    // reset in LD1 abandons the fill
    rq(1, 0, 32'h58, 0);
    #1;
    chk("ld58 miss dhit", dhit, 0);
    tick;
    dload = 32'h0000_0D00;
    tick;
    #1;
    chk("ld58 ld1 dREN", dREN, 1);
    nRST = 1'b0;
    #1;
    chk("midrst dREN", dREN, 0);
    chk("midrst daddr", daddr, 0);
    chk("midrst dhit", dhit, 0);
    chk("midrst dmemload", dmemload, 0);
    tick;
    nRST = 1'b1;
    miss_fill("reld58", 32'h58, 32'h0000_0D00, 32'h0000_0D04);
    #1;
    chk("reld58 data", dmemload, 32'h0000_0D00);
    tick;
    // dirty set 2 way 1 and set 7 way 0
    rq(1, 0, 32'h10, 0);
    miss_fill("ld10", 32'h10, 32'h0000_0010, 32'h0000_0014);
    rq(0, 1, 32'h50, 32'h0000_5050);
    miss_fill("st50", 32'h50, 32'h0000_0100, 32'h0000_0101);
    #1;
    chk("st50 dhit", dhit, 1);
    tick;
    rq(0, 1, 32'h38, 32'h0000_3838);
    miss_fill("st38", 32'h38, 32'h0000_0200, 32'h0000_0201);
    #1;
    chk("st38 dhit", dhit, 1);
    tick;
    // flush
    rq(0, 0, 0, 0);
    halt = 1;
    nw = 0;
    both = 0;
    cyc = 0;
    while (!flushed && cyc < 60) begin
      tick;
      #1;
      cyc++;
      if (dREN && dWEN) both++;
      if (dWEN) begin
        if (nw < 4) begin
          wa[nw] = daddr;
          wd[nw] = dstore;
        end
        nw++;
      end
    end
    chk("flush done", flushed, 1);
    chk("flush cycles", cyc, 21);
    chk("flush wen count", nw, 4);
    chk("flush both", both, 0);
    chk("fwb a0", wa[0], 32'h50);
    chk("fwb d0", wd[0], 32'h0000_5050);
    chk("fwb a1", wa[1], 32'h54);
    chk("fwb d1", wd[1], 32'h0000_0101);
    chk("fwb a2", wa[2], 32'h38);
    chk("fwb d2", wd[2], 32'h0000_3838);
    chk("fwb a3", wa[3], 32'h3C);
    chk("fwb d3", wd[3], 32'h0000_0201);
    halt = 0;
    rq(1, 0, 32'h10, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk("done flushed", flushed, 1);
      chk("done dhit", dhit, 0);
      chk("done dREN", dREN, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
